// File: rtl/song_sequencer.sv
// song_sequencer: walks one 16-entry song in the song ROM and hands note
// entries to the first idle note-player voice, holding for beat-counted waits
// on play entries.
//
// Ports:
//   clk, reset     system clock, asynchronous active-high reset
//   start          one-cycle pulse, accepted only in IDLE
//   song_sel       song index, sampled when start is accepted
//   play           level; low pauses beat counting and note issue
//   beat           one-cycle beat tick
//   rom_addr       registered ROM address (ROM answers one cycle later)
//   rom_dout       ROM entry
//   voice_free     per-voice idle flags
//   note_load      one-hot, one-cycle load strobe to the chosen voice
//   note_out       note number, valid with note_load
//   dur_out        note duration, valid with note_load
//   song_done      one-cycle pulse after the last entry completes
//   busy           high whenever the sequencer is not idle
module song_sequencer #(
  parameter int unsigned SONG_LEN   = 16,
  parameter int unsigned NUM_VOICES = 3,
  parameter int unsigned ADDR_W     = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            song_sel,
  input  logic                  play,
  input  logic                  beat,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [15:0]           rom_dout,
  input  logic [NUM_VOICES-1:0] voice_free,
  output logic [NUM_VOICES-1:0] note_load,
  output logic [5:0]            note_out,
  output logic [5:0]            dur_out,
  output logic                  song_done,
  output logic                  busy
);

  localparam int unsigned OFF_W   = $clog2(SONG_LEN);
  localparam int unsigned FIELD_W = 6;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DECODE,
    ISSUE,
    WAIT_BEATS,
    NEXT
  } state_t;

  state_t                  state, state_n;
  logic [ADDR_W-1:0]       base, base_n;
  logic [OFF_W-1:0]        offset, offset_n;
  logic [FIELD_W-1:0]      beat_cnt, beat_cnt_n;
  logic [FIELD_W-1:0]      note_r, note_r_n;
  logic [FIELD_W-1:0]      dur_r, dur_r_n;
  logic [ADDR_W-1:0]       rom_addr_n;
  logic [NUM_VOICES-1:0]   note_load_n;
  logic [FIELD_W-1:0]      note_out_n, dur_out_n;
  logic                    song_done_n, busy_n;

  // Entry fields; the low three bits of every entry carry nothing.
  logic                    entry_is_play;
  logic [FIELD_W-1:0]      entry_hi, entry_mid;
  logic                    rom_unused;

  assign entry_is_play = rom_dout[15];
  assign entry_hi      = rom_dout[14:9];
  assign entry_mid     = rom_dout[8:3];
  assign rom_unused    = ^rom_dout[2:0];

  // Lowest-index free voice as a one-hot vector (all zero when none free).
  logic [NUM_VOICES-1:0]   pick;
  logic                    found;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < int'(NUM_VOICES); i++) begin
      if (voice_free[i] && !found) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      base      <= '0;
      offset    <= '0;
      beat_cnt  <= '0;
      note_r    <= '0;
      dur_r     <= '0;
      rom_addr  <= '0;
      note_load <= '0;
      note_out  <= '0;
      dur_out   <= '0;
      song_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      base      <= base_n;
      offset    <= offset_n;
      beat_cnt  <= beat_cnt_n;
      note_r    <= note_r_n;
      dur_r     <= dur_r_n;
      rom_addr  <= rom_addr_n;
      note_load <= note_load_n;
      note_out  <= note_out_n;
      dur_out   <= dur_out_n;
      song_done <= song_done_n;
      busy      <= busy_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state;
    base_n      = base;
    offset_n    = offset;
    beat_cnt_n  = beat_cnt;
    note_r_n    = note_r;
    dur_r_n     = dur_r;
    rom_addr_n  = rom_addr;
    note_load_n = '0;
    note_out_n  = note_out;
    dur_out_n   = dur_out;
    song_done_n = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          base_n     = ADDR_W'(ADDR_W'(song_sel) * ADDR_W'(SONG_LEN));
          offset_n   = '0;
          rom_addr_n = base_n;
          state_n    = READ;
        end
      end

      READ: state_n = DECODE;

      DECODE: begin
        note_r_n = entry_hi;
        dur_r_n  = entry_mid;
        if (!entry_is_play) begin
          // A note number of zero is a rest: nothing to load.
          state_n = (entry_hi != '0) ? ISSUE : NEXT;
        end else if (entry_hi != '0) begin
          beat_cnt_n = entry_hi;
          state_n    = WAIT_BEATS;
        end else begin
          state_n = NEXT;
        end
      end

      ISSUE: begin
        if (play && found) begin
          note_load_n = pick;
          note_out_n  = note_r;
          dur_out_n   = dur_r;
          state_n     = NEXT;
        end
      end

      WAIT_BEATS: begin
        // Beats arriving while paused are dropped rather than remembered.
        if (beat && play) begin
          if (beat_cnt == FIELD_W'(1)) begin
            beat_cnt_n = '0;
            state_n    = NEXT;
          end else begin
            beat_cnt_n = beat_cnt - FIELD_W'(1);
          end
        end
      end

      NEXT: begin
        if (offset == OFF_W'(SONG_LEN - 1)) begin
          song_done_n = 1'b1;
          state_n     = IDLE;
        end else begin
          offset_n   = offset + OFF_W'(1);
          rom_addr_n = base + ADDR_W'(offset) + ADDR_W'(1);
          state_n    = READ;
        end
      end

      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: drives song_sequencer against a registered-read ROM
// model, checks voice loads through a scoreboard queue and the sequencing,
// waits, pause, done and reset behaviour with directed sequences.
module tb_song_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  song_sel = 2'd0;
  logic        play = 1'b1;
  logic        beat = 1'b0;
  logic [5:0]  rom_addr;
  logic [15:0] rom_dout;
  logic [2:0]  voice_free = 3'b111;
  logic [2:0]  note_load;
  logic [5:0]  note_out;
  logic [5:0]  dur_out;
  logic        song_done;
  logic        busy;

  song_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .song_sel   (song_sel),
    .play       (play),
    .beat       (beat),
    .rom_addr   (rom_addr),
    .rom_dout   (rom_dout),
    .voice_free (voice_free),
    .note_load  (note_load),
    .note_out   (note_out),
    .dur_out    (dur_out),
    .song_done  (song_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Song ROM with one cycle of read latency.
  logic [15:0] rom [64];
  always @(posedge clk) rom_dout <= rom[rom_addr];

  typedef struct packed {
    logic [2:0] load;
    logic [5:0] note;
    logic [5:0] dur;
  } exp_t;

  typedef struct {
    logic [2:0] vf;
    logic [5:0] note;
    logic [5:0] dur;
    logic [2:0] load;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[7];
  logic [2:0] prev_load = 3'b000;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic logic [15:0] note_e(input int n, input int d);
    return {1'b0, 6'(n), 6'(d), 3'b000};
  endfunction

  function automatic logic [15:0] wait_e(input int w);
    return {1'b1, 6'(w), 9'h000};
  endfunction

  // Scoreboard: every load strobe pops and compares the oldest expectation.
  always @(negedge clk) begin
    if (song_done) done_cnt++;
    if (!reset && note_load != 3'b000) begin
      check("load_single_cycle", int'(prev_load), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_load", int'(note_load), 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("load_voice", int'(note_load), int'(mon_e.load));
        check("load_note", int'(note_out), int'(mon_e.note));
        check("load_dur", int'(dur_out), int'(mon_e.dur));
      end
    end
    prev_load = reset ? 3'b000 : note_load;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input logic [2:0] l, input logic [5:0] n, input logic [5:0] d);
    exp_t e;
    e.load = l;
    e.note = n;
    e.dur  = d;
    exp_q.push_back(e);
  endtask

  // Returns just after the negedge on which a load strobe is visible.
  task automatic wait_load(input int budget, input string name);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (note_load == 3'b000 && k < budget);
    if (note_load == 3'b000) check({name, "_timeout"}, 0, 1);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!song_done && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!song_done) check("song_done_timeout", 0, 1);
  endtask

  task automatic pulse_beats(input int n);
    for (int b = 0; b < n; b++) begin
      beat = 1'b1;
      @(negedge clk);
      beat = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic start_song(input logic [1:0] sel);
    song_sel = sel;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int bad;
    int steps;
    int k;
    logic [5:0] prev;

    for (int i = 0; i < 64; i++) rom[i] = wait_e(0);
    // Song 0: three notes, a 12-beat wait, a 3-beat wait, a rest.
    rom[0] = note_e(63, 63);
    rom[1] = note_e(56, 5);
    rom[2] = note_e(59, 9);
    rom[3] = wait_e(12);
    rom[4] = wait_e(3);
    rom[5] = note_e(0, 7);
    // Song 1: stalled note then the voice-pick table.
    vecs[0] = '{3'b111, 6'd1,  6'd2,  3'b001};
    vecs[1] = '{3'b110, 6'd10, 6'd20, 3'b010};
    vecs[2] = '{3'b101, 6'd21, 6'd63, 3'b001};
    vecs[3] = '{3'b011, 6'd33, 6'd0,  3'b001};
    vecs[4] = '{3'b010, 6'd40, 6'd17, 3'b010};
    vecs[5] = '{3'b100, 6'd62, 6'd1,  3'b100};
    vecs[6] = '{3'b111, 6'd5,  6'd44, 3'b001};
    rom[16] = note_e(7, 33);
    for (int i = 0; i < 7; i++) rom[17 + i] = note_e(int'(vecs[i].note), int'(vecs[i].dur));
    // Song 3: long wait interrupted by reset.
    rom[48] = wait_e(10);

    // Reset state.
    cyc(2);
    check("rst_rom_addr", int'(rom_addr), 0);
    check("rst_note_load", int'(note_load), 0);
    check("rst_note_out", int'(note_out), 0);
    check("rst_dur_out", int'(dur_out), 0);
    check("rst_song_done", int'(song_done), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b0;
    cyc(1);

    // Song 0: first-note latency, voice rotation, beat waits, pause.
    voice_free = 3'b111;
    push_exp(3'b001, 6'd63, 6'd63);
    start_song(2'd0);
    check("s0_base_addr", int'(rom_addr), 0);
    check("s0_busy", int'(busy), 1);
    lat = 1;
    while (note_load == 3'b000 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("first_load_latency", lat, 4);
    #1;
    voice_free = 3'b110;
    push_exp(3'b010, 6'd56, 6'd5);
    wait_load(20, "load2");
    voice_free = 3'b100;
    push_exp(3'b100, 6'd59, 6'd9);
    wait_load(20, "load3");
    voice_free = 3'b111;
    cyc(3);
    check("wait12_addr", int'(rom_addr), 3);
    pulse_beats(11);
    check("wait12_after11", int'(rom_addr), 3);
    beat = 1'b1;
    @(negedge clk);
    beat = 1'b0;
    check("wait12_next", int'(rom_addr), 3);
    @(negedge clk);
    check("wait12_advance", int'(rom_addr), 4);
    cyc(2);
    play = 1'b0;
    pulse_beats(5);
    check("paused_hold", int'(rom_addr), 4);
    play = 1'b1;
    pulse_beats(2);
    cyc(3);
    check("resumed_hold", int'(rom_addr), 4);
    beat = 1'b1;
    @(negedge clk);
    beat = 1'b0;
    check("resumed_next", int'(rom_addr), 4);
    @(negedge clk);
    check("resumed_advance", int'(rom_addr), 5);
    wait_done(120);
    check("s0_busy_at_done", int'(busy), 0);
    cyc(2);
    check("s0_done_count", done_cnt, 1);

    // Song 1: no free voice for 20 cycles (start ignored meanwhile), then table.
    voice_free = 3'b000;
    start_song(2'd1);
    check("s1_base_addr", int'(rom_addr), 16);
    cyc(3);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        song_sel = 2'd3;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (note_load != 3'b000) bad++;
    end
    start = 1'b0;
    check("stall_no_load", bad, 0);
    check("stall_addr", int'(rom_addr), 16);
    check("stall_busy", int'(busy), 1);
    voice_free = 3'b100;
    push_exp(3'b100, 6'd7, 6'd33);
    wait_load(10, "stall_release");
    for (int i = 0; i < 7; i++) begin
      voice_free = vecs[i].vf;
      push_exp(vecs[i].load, vecs[i].note, vecs[i].dur);
      wait_load(20, "vec_load");
    end
    voice_free = 3'b111;
    wait_done(100);
    cyc(2);
    check("s1_done_count", done_cnt, 2);

    // Song 2: zero-wait entries walk 32..47; start coincident with done.
    start_song(2'd2);
    check("s2_base_addr", int'(rom_addr), 32);
    prev = rom_addr;
    steps = 0;
    bad = 0;
    k = 0;
    while (rom_addr != 6'd47 && k < 100) begin
      @(negedge clk);
      k++;
      if (rom_addr != prev) begin
        if (rom_addr != prev + 6'd1) bad++;
        steps++;
        prev = rom_addr;
      end
    end
    check("s2_addr_steps", steps, 15);
    check("s2_addr_order", bad, 0);
    cyc(2);
    check("s2_busy_last_next", int'(busy), 1);
    song_sel = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("s2_song_done", int'(song_done), 1);
    check("s2_busy_falls", int'(busy), 0);
    @(negedge clk);
    check("s2_start_ignored", int'(busy), 0);
    check("s2_done_single", int'(song_done), 0);
    check("s2_addr_hold", int'(rom_addr), 47);
    cyc(1);
    check("s2_done_count", done_cnt, 3);

    // Song 3: asynchronous reset during a wait, then replay from base.
    start_song(2'd3);
    check("s3_base_addr", int'(rom_addr), 48);
    cyc(2);
    pulse_beats(2);
    check("s3_busy_waiting", int'(busy), 1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_rom_addr", int'(rom_addr), 0);
    check("arst_note_load", int'(note_load), 0);
    check("arst_note_out", int'(note_out), 0);
    check("arst_dur_out", int'(dur_out), 0);
    check("arst_song_done", int'(song_done), 0);
    check("arst_busy", int'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    cyc(3);
    check("arst_no_done", done_cnt, 3);
    start_song(2'd3);
    check("replay_base_addr", int'(rom_addr), 48);
    check("replay_busy", int'(busy), 1);
    cyc(2);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
